// File: rtl/ddr_rd_capture_to_bram_if.sv
// Bus bundle for ddr_rd_capture_to_bram: the MIG read-data stream in and the BRAM write port out.
// The capture block is the slave; the MIG/BRAM side (or a bench) is the master.
interface ddr_rd_capture_to_bram_if #(
    parameter int APP_DATA_WIDTH  = 64,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
);
    logic [APP_DATA_WIDTH-1:0]  app_rd_data;
    logic                       app_rd_data_valid;
    logic                       app_rd_data_end;
    logic                       bram_wr_grant;
    logic                       bram_en;
    logic                       bram_we;
    logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
    logic [BRAM_DATA_WIDTH-1:0] bram_wdata;

    modport slave (
        input  app_rd_data, app_rd_data_valid, app_rd_data_end, bram_wr_grant,
        output bram_en, bram_we, bram_addr, bram_wdata
    );

    modport master (
        output app_rd_data, app_rd_data_valid, app_rd_data_end, bram_wr_grant,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/ddr_rd_capture_to_bram.sv
// Captures MIG read beats into a small FIFO and writes them to BRAM as slices, low slice first.
// Optional checksum output (XOR of all stored beats) when RD_CAPTURE_CHECKSUM_EN is defined.
module ddr_rd_capture_to_bram #(
    parameter int APP_DATA_WIDTH  = 64,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_WIDTH       = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_calib_complete,
    input  logic                       capture_en,
    input  logic [BRAM_ADDR_WIDTH-1:0] bram_begin_addr,
    input  logic [CNT_WIDTH-1:0]       beat_count,
    ddr_rd_capture_to_bram_if.slave    bus,
    output logic                       busy,
    output logic                       capture_done,
    output logic                       overflow
`ifdef RD_CAPTURE_CHECKSUM_EN
    ,output logic [APP_DATA_WIDTH-1:0] checksum
`endif
);
    localparam int RATIO   = APP_DATA_WIDTH / BRAM_DATA_WIDTH;
    localparam int SLICE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(RATIO - 1);
    localparam logic [PTR_W:0]     FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       count_lat_q, count_lat_d;
    logic [CNT_WIDTH-1:0]       beats_rcvd_q, beats_rcvd_d, beats_next;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SLICE_W-1:0]         slice_q, slice_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]             fifo_cnt_q, fifo_cnt_d;
    logic                       stg_vld_q, stg_vld_d;
    logic [APP_DATA_WIDTH-1:0]  stg_data_q, stg_data_d;
    logic                       bram_en_q, bram_en_d;
    logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [BRAM_DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;
    logic                       capture_done_q, capture_done_d;
    logic                       overflow_q, overflow_d;
    logic [APP_DATA_WIDTH-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [APP_DATA_WIDTH-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic [APP_DATA_WIDTH-1:0]  head;
    logic                       fifo_empty, fifo_full, push, pop, issue;
    logic                       unused_rd_end;
`ifdef RD_CAPTURE_CHECKSUM_EN
    logic [APP_DATA_WIDTH-1:0]  checksum_q, checksum_d;
`endif

    assign unused_rd_end = bus.app_rd_data_end;
    assign fifo_empty    = (fifo_cnt_q == '0);
    assign fifo_full     = (fifo_cnt_q == FIFO_FULL);
    assign head          = fifo_mem_q[rd_ptr_q];
    assign beats_next    = beats_rcvd_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        count_lat_d    = count_lat_q;
        beats_rcvd_d   = beats_rcvd_q;
        addr_d         = addr_q;
        slice_d        = slice_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        stg_vld_d      = 1'b0;
        stg_data_d     = stg_data_q;
        bram_en_d      = 1'b0;
        bram_addr_d    = bram_addr_q;
        bram_wdata_d   = bram_wdata_q;
        capture_done_d = 1'b0;
        overflow_d     = overflow_q;
        fifo_mem_d     = fifo_mem_q;
        push           = 1'b0;
        pop            = 1'b0;
`ifdef RD_CAPTURE_CHECKSUM_EN
        checksum_d     = checksum_q;
`endif

        // Accepted beats sit one cycle in the staging register before the FIFO.
        if (stg_vld_q) begin
            if (!fifo_full) push = 1'b1;
            else            overflow_d = 1'b1;
        end

        issue = ((state_q == S_CAPTURE) || (state_q == S_DRAIN)) && !fifo_empty && bus.bram_wr_grant;
        if (issue) begin
            bram_en_d    = 1'b1;
            bram_addr_d  = addr_q;
            bram_wdata_d = head[slice_q*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
            addr_d       = addr_q + 1'b1;
            if (slice_q == SLICE_LAST) begin
                slice_d = '0;
                pop     = 1'b1;
            end else begin
                slice_d = slice_q + 1'b1;
            end
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = stg_data_q;
            wr_ptr_d             = wr_ptr_q + 1'b1;
`ifdef RD_CAPTURE_CHECKSUM_EN
            checksum_d           = checksum_q ^ stg_data_q;
`endif
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (capture_en) begin
                    count_lat_d  = beat_count;
                    addr_d       = bram_begin_addr;
                    beats_rcvd_d = '0;
                    slice_d      = '0;
                    overflow_d   = 1'b0;
`ifdef RD_CAPTURE_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                    state_d      = (beat_count == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.app_rd_data_valid) begin
                    stg_vld_d    = 1'b1;
                    stg_data_d   = bus.app_rd_data;
                    beats_rcvd_d = beats_next;
                    if (beats_next == count_lat_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.app_rd_data_valid) overflow_d = 1'b1;
                if (fifo_empty && (slice_q == '0) && !stg_vld_q && !issue) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.app_rd_data_valid) overflow_d = 1'b1;
                capture_done_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !init_calib_complete) begin
            state_q        <= S_IDLE;
            count_lat_q    <= '0;
            beats_rcvd_q   <= '0;
            addr_q         <= '0;
            slice_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            stg_vld_q      <= 1'b0;
            stg_data_q     <= '0;
            bram_en_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_wdata_q   <= '0;
            capture_done_q <= 1'b0;
            overflow_q     <= 1'b0;
`ifdef RD_CAPTURE_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            count_lat_q    <= count_lat_d;
            beats_rcvd_q   <= beats_rcvd_d;
            addr_q         <= addr_d;
            slice_q        <= slice_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            stg_vld_q      <= stg_vld_d;
            stg_data_q     <= stg_data_d;
            bram_en_q      <= bram_en_d;
            bram_addr_q    <= bram_addr_d;
            bram_wdata_q   <= bram_wdata_d;
            capture_done_q <= capture_done_d;
            overflow_q     <= overflow_d;
`ifdef RD_CAPTURE_CHECKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign bus.bram_en    = bram_en_q;
    assign bus.bram_we    = bram_en_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_wdata = bram_wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign capture_done   = capture_done_q;
    assign overflow       = overflow_q;
`ifdef RD_CAPTURE_CHECKSUM_EN
    assign checksum       = checksum_q;
`endif
endmodule

// File: doc/ddr_rd_capture_to_bram.md
Name: ddr_rd_capture_to_bram

Overview:
- Downstream stage of the DDR burst controller.
- Consumes the MIG read-data stream (app_rd_data / app_rd_data_valid) that the controller's read commands produce, and writes it into a BRAM port.
- Buffers beats in a small FIFO, splits each DDR word into BRAM-width slices (low slice first), and waits on an external BRAM write grant.
- Reports completion and overflow to the sequencing logic.

Parameters:
- APP_DATA_WIDTH, 64, DDR read-data word width.
- BRAM_DATA_WIDTH, 32, BRAM write width; APP_DATA_WIDTH must be an integer multiple of it; RATIO = APP_DATA_WIDTH/BRAM_DATA_WIDTH.
- BRAM_ADDR_WIDTH, 10, BRAM word-address width.
- FIFO_DEPTH, 16, capture FIFO depth in DDR words; must be a power of 2.
- CNT_WIDTH, 7, width of the beat counters and beat_count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- init_calib_complete  in  1  low: block held in reset state.
- capture_en  in  1  start pulse; sampled only in IDLE.
- bram_begin_addr  in  BRAM_ADDR_WIDTH  first BRAM address of the capture.
- beat_count  in  CNT_WIDTH  DDR beats expected; sampled with capture_en.
- app_rd_data  in  APP_DATA_WIDTH  MIG read data.
- app_rd_data_valid  in  1  read beat valid.
- app_rd_data_end  in  1  unused; ignored.
- bram_wr_grant  in  1  arbiter grant; a slice is issued only when high.
- bram_en  out  1  BRAM enable (registered).
- bram_we  out  1  BRAM write enable (registered, equals bram_en).
- bram_addr  out  BRAM_ADDR_WIDTH  BRAM address (registered).
- bram_wdata  out  BRAM_DATA_WIDTH  BRAM data (registered).
- busy  out  1  high in any state except IDLE.
- capture_done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset: all state is cleared when rst_n=0 or init_calib_complete=0.
  - Reset values: state=IDLE, FIFO empty, counters 0, slice index 0, all outputs 0.
  - Reset mid-capture aborts the capture with no done pulse.
- States are IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - capture_en=1 latches beat_count, loads the address register with bram_begin_addr, clears beats_rcvd and overflow, and moves to CAPTURE.
  - If the latched count is 0, the block goes to DONE instead.
  - app_rd_data_valid is ignored in IDLE.
- Beat acceptance (CAPTURE only):
  - Each valid cycle increments beats_rcvd.
  - The beat is pushed to the FIFO if not full.
  - If the FIFO is full, the beat is dropped, overflow is set, and beats_rcvd still increments.
- Valid after the count is reached: a valid in DRAIN or DONE (beats_rcvd==count) is dropped and sets overflow.
- CAPTURE->DRAIN: on the cycle beats_rcvd reaches the latched count.
- Slice issue (CAPTURE or DRAIN):
  - Condition: FIFO non-empty and bram_wr_grant=1.
  - Next edge: bram_en=bram_we=1, bram_addr = address register, bram_wdata = head word slice [slice*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH].
  - The address register increments and wraps modulo 2^BRAM_ADDR_WIDTH.
  - The slice index increments; at RATIO-1 it returns to 0 and the FIFO head is popped.
  - Without a grant, bram_en=0 and no state advances (no slice skipped).
- Latency: a valid beat at edge k makes bram_en high no earlier than the cycle after edge k+2, given a continuous grant.
- Simultaneous push and pop in one cycle are both performed; the count is unchanged.
- DRAIN->DONE: when the FIFO is empty, slice index is 0, and no issue is pending.
- DONE: capture_done=1 for exactly one cycle, then IDLE.
- Zero-beat capture: capture_en -> DONE -> IDLE, capture_done two cycles after capture_en.
- capture_en while busy is ignored.
- overflow holds until the next accepted capture_en or reset.

Optional Feature:
- Macro RD_CAPTURE_CHECKSUM_EN.
- Defined:
  - Adds output checksum (APP_DATA_WIDTH), registered, reset 0, cleared on an accepted capture_en.
  - XOR-accumulates every beat pushed into the FIFO; dropped beats are excluded.
  - Stable from the capture_done cycle until the next capture_en.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic capture: bram_begin_addr=0x010, beat_count=4, grant tied 1, beats 0x1111_2222_3333_4444 +1 per beat -> 8 BRAM writes at addr 0x010..0x017, first data 0x3333_4444 then 0x1111_2222; capture_done one pulse; overflow=0.
- Grant stall: grant=0 while 6 beats arrive, then grant=1 -> no bram_en during the stall; 12 writes in order afterward with no gaps; done after the last write.
- Overflow: FIFO_DEPTH=16, grant=0, beat_count=20, 20 consecutive valids -> 16 stored, overflow=1 from the 17th beat; grant=1 -> 32 writes, capture_done, overflow stays 1 until the next capture_en.
- Address wrap: bram_begin_addr=0x3FE, beat_count=2 -> writes to 0x3FE, 0x3FF, 0x000, 0x001.
- Edge cases:
  - beat_count=0 -> capture_done two cycles after capture_en, no bram_en.
  - capture_en during CAPTURE -> ignored.
  - Valid in IDLE -> no write, overflow=0.
- Reset mid-run: rst_n=0 for 1 cycle after 2 of 4 beats -> all outputs 0, busy=0, no capture_done; a new capture then completes normally.
